// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with programmable period, prescaler and inversion.
// Period, prescale and duty values are staged and applied together at period wrap.
module pwm_bank #(
    parameter int NUM_CH  = 16,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [6:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    logic [NUM_CH-1:0]  out_en_q, out_en_d;
    logic [NUM_CH-1:0]  pwm_en_q, pwm_en_d;
    logic               inv_q, inv_d;
    logic [7:0]         top_s_q, top_s_d;
    logic [7:0]         top_q, top_d;
    logic [PRESC_W-1:0] presc_s_q, presc_s_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         duty_s_q [NUM_CH];
    logic [7:0]         duty_s_d [NUM_CH];
    logic [7:0]         duty_q [NUM_CH];
    logic [7:0]         duty_d [NUM_CH];
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [NUM_CH-1:0]  out_q, out_d;
    logic               ps_q, ps_d;
    logic               tick;
    logic               upd;

    always_comb begin
        out_en_d  = out_en_q;
        pwm_en_d  = pwm_en_q;
        inv_d     = inv_q;
        top_s_d   = top_s_q;
        top_d     = top_q;
        presc_s_d = presc_s_q;
        presc_d   = presc_q;
        duty_s_d  = duty_s_q;
        duty_d    = duty_q;
        out_d     = '0;

        tick   = (pcnt_q == presc_q);
        upd    = tick && (cnt_q == top_q);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        cnt_d  = cnt_q;
        if (tick) begin
            cnt_d = upd ? 8'd0 : cnt_q + 8'd1;
        end

        // Live copies take the staged values before this cycle's write lands
        if (upd) begin
            top_d   = top_s_q;
            presc_d = presc_s_q;
            duty_d  = duty_s_q;
        end

        if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == 7'(i / 8)) begin
                    out_en_d[i] = wr_data[i % 8];
                end
                if (wr_addr == 7'(4 + i / 8)) begin
                    pwm_en_d[i] = wr_data[i % 8];
                end
                if (wr_addr == 7'(16 + i)) begin
                    duty_s_d[i] = wr_data;
                end
            end
            case (wr_addr)
                7'h08:   inv_d     = wr_data[0];
                7'h09:   top_s_d   = wr_data;
                7'h0A:   presc_s_d = wr_data[PRESC_W-1:0];
                default: ;
            endcase
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (out_en_q[i]) begin
                out_d[i] = pwm_en_q[i] ? ((cnt_q < duty_q[i]) ^ inv_q) : 1'b1;
            end
        end
        ps_d = (cnt_q == 8'd0) && (pcnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_en_q  <= '0;
            pwm_en_q  <= '0;
            inv_q     <= 1'b0;
            top_s_q   <= 8'hFF;
            top_q     <= 8'hFF;
            presc_s_q <= '0;
            presc_q   <= '0;
            duty_s_q  <= '{default: '0};
            duty_q    <= '{default: '0};
            pcnt_q    <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            ps_q      <= 1'b0;
        end else begin
            out_en_q  <= out_en_d;
            pwm_en_q  <= pwm_en_d;
            inv_q     <= inv_d;
            top_s_q   <= top_s_d;
            top_q     <= top_d;
            presc_s_q <= presc_s_d;
            presc_q   <= presc_d;
            duty_s_q  <= duty_s_d;
            duty_q    <= duty_d;
            pcnt_q    <= pcnt_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            ps_q      <= ps_d;
        end
    end

    assign out          = out_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank against a period-position reference model.
// Expected outputs are derived from time-in-period arithmetic each clock.
module tb_pwm_bank;

    localparam int NCH = 16;
    localparam int PW  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_en = 1'b0;
    logic [6:0]     wr_addr = '0;
    logic [7:0]     wr_data = '0;
    logic [NCH-1:0] out;
    logic           period_start;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_bank #(.NUM_CH(NCH), .PRESC_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .out          (out),
        .period_start (period_start)
    );

    typedef struct {
        logic [NCH-1:0] o;
        logic           ps;
    } exp_t;

    exp_t sb[$];

    // Reference state: programmer-visible registers plus clocks into period
    bit [NCH-1:0] m_oen, m_pen;
    bit           m_inv;
    int           m_top_s, m_top_l, m_pre_s, m_pre_l, m_t;
    int           m_duty_s[NCH];
    int           m_duty_l[NCH];

    function automatic int plen();
        return (m_top_l + 1) * (m_pre_l + 1);
    endfunction

    always @(posedge clk) begin : model
        exp_t e;
        int   c;
        int   a;
        e.o  = '0;
        e.ps = 1'b0;
        if (!rst) begin
            c    = m_t / (m_pre_l + 1);
            e.ps = (m_t == 0);
            for (int i = 0; i < NCH; i++) begin
                if (m_oen[i]) begin
                    e.o[i] = m_pen[i] ? ((c < m_duty_l[i]) ^ m_inv) : 1'b1;
                end
            end
        end
        sb.push_back(e);
        if (rst) begin
            m_oen = '0; m_pen = '0; m_inv = 1'b0;
            m_top_s = 255; m_top_l = 255;
            m_pre_s = 0; m_pre_l = 0; m_t = 0;
            for (int i = 0; i < NCH; i++) begin
                m_duty_s[i] = 0;
                m_duty_l[i] = 0;
            end
        end else begin
            if (m_t + 1 == plen()) begin
                m_t     = 0;
                m_top_l = m_top_s;
                m_pre_l = m_pre_s;
                for (int i = 0; i < NCH; i++) m_duty_l[i] = m_duty_s[i];
            end else begin
                m_t++;
            end
            if (wr_en) begin
                a = int'(wr_addr);
                if (a < 4) begin
                    for (int i = 0; i < NCH; i++)
                        if (i / 8 == a) m_oen[i] = wr_data[i % 8];
                end else if (a < 8) begin
                    for (int i = 0; i < NCH; i++)
                        if (i / 8 == a - 4) m_pen[i] = wr_data[i % 8];
                end else if (a == 8) begin
                    m_inv = wr_data[0];
                end else if (a == 9) begin
                    m_top_s = int'(wr_data);
                end else if (a == 10) begin
                    m_pre_s = int'(wr_data) & ((1 << PW) - 1);
                end else if (a >= 16 && a < 16 + NCH) begin
                    m_duty_s[a-16] = int'(wr_data);
                end
            end
        end
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (out !== e.o || period_start !== e.ps) begin
                errors++;
                $display("FAIL outputs t=%0t: out=%h ps=%b, expected out=%h ps=%b",
                         $time, out, period_start, e.o, e.ps);
            end
        end
    end

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_event_cycle();
        int k;
        k = 0;
        while (m_t != plen() - 1 && k < 70000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (m_t != plen() - 1) begin
            errors++;
            $display("FAIL event_wait: timed out after %0d cycles, required update cycle", k);
        end
    endtask

    initial begin
        int r;
        logic [6:0] a;
        logic [7:0] d;
        idle(3);
        rst = 1'b0;
        idle(600);

        wr(7'h00, 8'h01);
        idle(20);

        wr(7'h04, 8'h01);
        wr(7'h10, 8'h40);
        idle(600);
        wr(7'h10, 8'h00);
        idle(300);
        wr(7'h10, 8'hFF);
        idle(600);

        wr(7'h00, 8'h09);
        wr(7'h04, 8'h09);
        wr(7'h13, 8'h05);
        wr(7'h09, 8'h09);
        wr(7'h0A, 8'h02);
        idle(400);

        wr(7'h00, 8'h1B);
        wr(7'h04, 8'h0B);
        wr(7'h11, 8'h40);
        wr(7'h08, 8'h01);
        idle(200);
        wr(7'h09, 8'hFF);
        wr(7'h0A, 8'h00);
        idle(600);
        wr(7'h08, 8'h00);

        wr(7'h00, 8'h04);
        wr(7'h04, 8'h04);
        wr(7'h12, 8'h20);
        idle(300);
        wait_event_cycle();
        wr(7'h12, 8'h80);
        idle(600);

        wr(7'h09, 8'h30);
        idle(100);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(300);

        for (int n = 0; n < 20000; n++) begin
            r = int'($urandom_range(0, 2999));
            if (r == 0) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end else if (r < 80) begin
                r = int'($urandom_range(0, 9));
                if (r < 4)       a = 7'($urandom_range(0, 10));
                else if (r < 9)  a = 7'($urandom_range(16, 16 + NCH - 1));
                else             a = 7'($urandom_range(0, 127));
                d = 8'($urandom);
                if (a == 7'h0A) d = 8'($urandom_range(0, 3));
                wr(a, d);
            end else begin
                idle(1);
            end
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
Next-generation PWM peripheral. It generalises the fixed 16-output enable/PWM block to NUM_CH channels, each with its own duty cycle. It adds a programmable period, a clock prescaler, output inversion, and glitch-free shadowed updates at period boundaries. It sits behind the SPI register interface, which drives its byte-wide write port, and its outputs drive the chip's output pins.

Parameters:
NUM_CH, 16, number of PWM channels (1..32)
PRESC_W, 8, width of the prescaler register/counter (1..8)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
wr_en  input  1  register write strobe, one write per cycle high
wr_addr  input  7  register address
wr_data  input  8  register write data
out  output  NUM_CH  channel outputs, registered
period_start  output  1  one-cycle pulse on the first clock of each PWM period

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (rst). All state is updated on the rising edge of clk.
- Register map (8-bit data). Writes to unmapped addresses are ignored; there is no read port.
  - 0x00-0x03 OUT_EN bytes 0..3: bit i is the output enable of channel i. Bits at or above NUM_CH are ignored.
  - 0x04-0x07 PWM_EN bytes 0..3: bit i is the PWM enable of channel i. Bits at or above NUM_CH are ignored.
  - 0x08 CTRL: bit0 is INV (invert all PWM waveforms). Bits 7:1 are ignored.
  - 0x09 TOP: period top value, staged.
  - 0x0A PRESC: prescale value, staged. Only the low PRESC_W bits are stored.
  - 0x10+i DUTY[i], staged, for i < NUM_CH. Writes to 0x10+i with i >= NUM_CH are ignored.
- Staged vs live registers:
  - Each staged register has a live copy.
  - At an update event, all live copies load from their staged copies in the same cycle, so the update is atomic.
  - OUT_EN, PWM_EN and CTRL take effect immediately after the write cycle.
- Prescaler:
  - pcnt counts 0..PRESC_live.
  - tick is high when pcnt == PRESC_live; pcnt then wraps to 0.
  - PRESC_live = 0 gives a tick every clock.
- Period counter:
  - cnt advances by 1 on each tick.
  - On a tick with cnt == TOP_live, cnt wraps to 0 and the update event fires in that same cycle.
  - Period length = (TOP_live+1)*(PRESC_live+1) clocks.
- Compare: raw_i = (cnt < DUTY_live[i]), using an 8-bit unsigned compare.
  - DUTY = 0 gives a constant low.
  - DUTY > TOP gives a constant high.
  - DUTY = TOP+1 (TOP < 255) gives 100%.
- pwm_i = raw_i XOR INV.
- Output select, registered, computed from the current-cycle state:
  - OUT_EN[i] = 0: out[i] = 0.
  - OUT_EN[i] = 1 and PWM_EN[i] = 0: out[i] = 1 (static high, INV does not apply).
  - OUT_EN[i] = 1 and PWM_EN[i] = 1: out[i] = pwm_i.
- period_start is registered alongside out. It is high in the cycle where out reflects cnt = 0 of a new period (including the first period after reset).
- Reset values:
  - out = 0, period_start = 0.
  - All enables 0, INV 0.
  - TOP staged = live = 0xFF; PRESC staged = live = 0; DUTY staged = live = 0.
  - pcnt = 0, cnt = 0.
- Simultaneous events:
  - A staged write in the same cycle as an update event is not taken into that event's update. The live copy loads the old staged value; the new value applies at the next event.
  - A second write to the same staged register before the event replaces the first; the last write wins.
- Reducing TOP (staged) below the current cnt has no effect until the update event. The current period always completes with the old TOP.
- rst asserted mid-period: the next cycle is in the reset state, and staged writes in progress are discarded.

Test Plan:
- Reset, then all-zero enables -> out = 0 for 600 cycles. period_start pulses every 256 clocks (TOP = 0xFF, PRESC = 0).
- OUT_EN0 = 0x01, PWM_EN0 = 0x00 -> out[0] = 1 from the second cycle after the write; other outputs stay 0.
- OUT_EN0 = PWM_EN0 = 0x01, DUTY[0] = 0x40 -> after the next period_start, out[0] is high for 64 and low for 192 clocks per period. 0x00 gives constant 0; 0xFF gives high 255 of 256 clocks.
- TOP = 9, PRESC = 2, DUTY[3] = 5, channel 3 enabled -> period = 30 clocks, out[3] high 15 clocks. The old 256-clock period completes before the new values take effect.
- INV = 1 with DUTY[1] = 0x40 -> out[1] low 64 and high 192 clocks. A channel with PWM_EN = 0 stays static high.
- DUTY[2] written on the exact update-event cycle -> live duty unchanged for that period and applied one period later. rst asserted mid-period -> out = 0 and live TOP = 0xFF on the next cycle.
